// File: rtl/obuft_ds_tx_pkg.sv
// obuft_ds_tx_pkg
// Shared types and sizing helpers for the O_BUFT_DS transmit driver.
//   tx_state_e : transmit FSM states (IDLE, LEAD, SHIFT, GAP, TRAIL)
//   cnt_w()    : width of a counter that must hold 0..n-1 (never below 1 bit)
//   max_int()  : larger of two integers, used to size the shared lead/trail counter
package obuft_ds_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        GAP,
        TRAIL
    } tx_state_e;

    // $clog2(1) is 0, which would produce a zero-width counter, so clamp to 1.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/obuft_ds_tx_tick.sv
// obuft_ds_tx_tick
// Bit-period divider. Counts CLK_DIV clocks and raises tick for one clock at
// the end of every bit period.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : restart the period at 0 on the next clock (driven on every state change)
//   tick  : high in the final clock of the current bit period
module obuft_ds_tx_tick
    import obuft_ds_tx_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = cnt_w(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/obuft_ds_tx_driver.sv
// obuft_ds_tx_driver
// Serial transmit driver for a differential tri-state output buffer (O_BUFT_DS).
// Parallel words arrive over valid/ready and leave LSB-first on data_o. Each
// burst is framed by lead and trail periods at level 1 while the pad is driven;
// between bursts the pad is released (oe_o=0, data_o=0).
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   in_data    : word to send, sampled only at a handshake
//   in_last    : word closes the burst, sampled only at a handshake
//   in_valid   : word available
//   in_ready   : combinational from state/counters, never from in_valid
//   data_o     : registered serial data, to buffer I
//   oe_o       : registered drive enable, to buffer T (1 = driven)
//   busy       : registered, high whenever the FSM is not IDLE
// Build option: define OBUFT_DS_TX_PARITY_EN to append an even-parity bit
// (^word) after every word.
module obuft_ds_tx_driver
    import obuft_ds_tx_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CLK_DIV  = 1,
    parameter int PRE_CYC  = 2,
    parameter int POST_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              data_o,
    output logic              oe_o,
    output logic              busy
);

`ifdef OBUFT_DS_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // The shift register carries the data bits plus the optional parity bit,
    // so the parity bit is simply the last one shifted out.
    localparam int SH_W  = DATA_W + PAR_BITS;
    localparam int IDX_W = cnt_w(DATA_W + 1);
    localparam int PER_W = cnt_w(max_int(PRE_CYC, POST_CYC));

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SH_W - 1);
    localparam logic [PER_W-1:0] PRE_LAST  = PER_W'(PRE_CYC - 1);
    localparam logic [PER_W-1:0] POST_LAST = PER_W'(POST_CYC - 1);

    tx_state_e        state_q, state_d;
    logic [SH_W-1:0]  shreg_q, shreg_d;
    logic             last_q, last_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PER_W-1:0] per_q, per_d;
    logic             data_q, data_d;
    logic             oe_q, oe_d;
    logic             busy_q, busy_d;

    logic             tick;
    logic             clr;
    logic             final_bit;
    logic             hs;
    logic [SH_W-1:0]  load_word;

`ifdef OBUFT_DS_TX_PARITY_EN
    assign load_word = {^in_data, in_data};
`else
    assign load_word = in_data;
`endif

    obuft_ds_tx_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .tick (tick)
    );

    // Final clock of the final bit of a word: the only clock inside SHIFT
    // where a following word of the same burst may be accepted.
    assign final_bit = (state_q == SHIFT) && tick && (idx_q == IDX_LAST);
    assign in_ready  = (state_q == IDLE) || (state_q == GAP) || (final_bit && !last_q);
    assign hs        = in_valid && in_ready;
    assign clr       = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        last_d  = last_q;
        idx_d   = idx_q;
        per_d   = per_q;

        case (state_q)
            IDLE: begin
                if (hs) begin
                    shreg_d = load_word;
                    last_d  = in_last;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (tick) begin
                    if (per_q == PRE_LAST) begin
                        state_d = SHIFT;
                    end else begin
                        per_d = per_q + PER_W'(1);
                    end
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (idx_q == IDX_LAST) begin
                        // hs here can only happen when the burst is still open,
                        // so the new word follows with no gap.
                        if (hs) begin
                            shreg_d = load_word;
                            last_d  = in_last;
                            idx_d   = '0;
                        end else if (last_q) begin
                            state_d = TRAIL;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            GAP: begin
                if (hs) begin
                    shreg_d = load_word;
                    last_d  = in_last;
                    state_d = SHIFT;
                end
            end
            TRAIL: begin
                if (tick) begin
                    if (per_q == POST_LAST) begin
                        state_d = IDLE;
                    end else begin
                        per_d = per_q + PER_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            idx_d = '0;
            per_d = '0;
        end

        // Outputs are registered from the next state so they line up with it;
        // outside SHIFT the driven level is 1, and 0 when the pad is released.
        oe_d   = (state_d != IDLE);
        busy_d = (state_d != IDLE);
        data_d = (state_d == SHIFT) ? shreg_d[0] : (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            per_q   <= '0;
            data_q  <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            per_q   <= per_d;
            data_q  <= data_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
        end
    end

    assign data_o = data_q;
    assign oe_o   = oe_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_obuft_ds_tx_driver.sv
// tb_obuft_ds_tx_driver
// Scoreboard bench for obuft_ds_tx_driver. A behavioural model turns every
// accepted word into the list of per-clock pad levels it must produce (lead,
// bits, optional parity, trail) and the in_ready level expected in each clock.
// The stimulus side pushes one expected entry per clock; a monitor on the
// falling edge pops and compares. Honours OBUFT_DS_TX_PARITY_EN.
module tb_obuft_ds_tx_driver;

    localparam int DATA_W   = 8;
    localparam int CLK_DIV  = 2;
    localparam int PRE_CYC  = 2;
    localparam int POST_CYC = 3;

`ifdef OBUFT_DS_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              in_valid = 1'b0;
    wire               in_ready;
    wire               data_o;
    wire               oe_o;
    wire               busy;

    typedef struct packed {
        logic oe;
        logic data;
        logic ready;
    } entry_t;

    entry_t plan[$];
    entry_t sb[$];
    entry_t mon_e;
    bit     burst_open = 1'b0;
    int     errors = 0;
    int     checks = 0;

    obuft_ds_tx_driver #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV),
        .PRE_CYC (PRE_CYC),
        .POST_CYC(POST_CYC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_last (in_last),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_o  (data_o),
        .oe_o    (oe_o),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Compare one observed value with the expected one and log any difference.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic entry_t mk(input logic oe, input logic data, input logic ready);
        entry_t e;
        e.oe    = oe;
        e.data  = data;
        e.ready = ready;
        return e;
    endfunction

    // With nothing scheduled the pad either waits in the gap of an open burst
    // (driven high, ready) or is released (ready).
    function automatic entry_t nextEntry();
        if (plan.size() > 0) begin
            return plan.pop_front();
        end
        return burst_open ? mk(1'b1, 1'b1, 1'b1) : mk(1'b0, 1'b0, 1'b1);
    endfunction

    // Schedule the clocks an accepted word produces, starting the next clock.
    task automatic appendWord(input logic [DATA_W-1:0] w, input logic last, input bit from_idle);
        logic [DATA_W:0] seq;
        int              nbits;
        seq   = {^w, w};
        nbits = DATA_W + PAR_BITS;
        if (from_idle) begin
            repeat (PRE_CYC * CLK_DIV) plan.push_back(mk(1'b1, 1'b1, 1'b0));
        end
        for (int j = 0; j < nbits; j++) begin
            for (int c = 0; c < CLK_DIV; c++) begin
                plan.push_back(mk(1'b1, seq[j], (j == nbits - 1) && (c == CLK_DIV - 1) && !last));
            end
        end
        if (last) begin
            repeat (POST_CYC * CLK_DIV) plan.push_back(mk(1'b1, 1'b1, 1'b0));
        end
        burst_open = !last;
    endtask

    // One clock of stimulus: record what this clock must show, drive the
    // inputs, and if the model says the word is taken at the coming edge,
    // schedule its response.
    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic l,
                                 output bit accepted);
        entry_t cur;
        @(posedge clk);
        #1;
        cur = nextEntry();
        sb.push_back(cur);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        accepted = v && cur.ready;
        if (accepted) begin
            appendWord(d, l, !cur.oe);
        end
    endtask

    task automatic sendWord(input logic [DATA_W-1:0] d, input logic l);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            applyStimulus(1'b1, d, l, acc);
            n++;
        end
        if (!acc) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic idleCycles(input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, DATA_W'($urandom), 1'($urandom), acc);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checkOutput("oe_o", 32'(oe_o), 32'(mon_e.oe));
            checkOutput("data_o", 32'(data_o), 32'(mon_e.data));
            checkOutput("in_ready", 32'(in_ready), 32'(mon_e.ready));
            checkOutput("busy", 32'(busy), 32'(mon_e.oe));
        end
    end

    initial begin
        bit acc;
        int n;

        // Reset state while rst_n is held low.
        #12;
        checkOutput("rst_oe", 32'(oe_o), 32'd0);
        checkOutput("rst_data", 32'(data_o), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word closing its own burst.
        sendWord(8'hA5, 1'b1);
        idleCycles(40);

        // Back-to-back burst: second word held valid until accepted.
        sendWord(8'h0F, 1'b0);
        sendWord(8'hF0, 1'b1);
        idleCycles(40);

        // Underrun: the burst sits in GAP before the next word arrives.
        sendWord(8'h01, 1'b0);
        idleCycles(24);
        sendWord(8'h80, 1'b0);
        sendWord(8'h07, 1'b1);
        idleCycles(40);

        // Reset in the middle of a word, then a fresh burst from LEAD.
        sendWord(8'hA5, 1'b1);
        idleCycles(9);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_oe", 32'(oe_o), 32'd0);
        checkOutput("midrst_data", 32'(data_o), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        plan.delete();
        burst_open = 1'b0;
        idleCycles(2);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_ready", 32'(in_ready), 32'd1);
        sendWord(8'h3C, 1'b1);
        idleCycles(40);

        // Random traffic: gaps, back-to-back words and short bursts.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), DATA_W'($urandom),
                          ($urandom_range(0, 4) == 0), acc);
        end

        // Close any open burst and let everything drain.
        if (burst_open) begin
            sendWord(8'h5A, 1'b1);
        end
        n = 0;
        while (plan.size() > 0 && n < 400) begin
            applyStimulus(1'b0, '0, 1'b0, acc);
            n++;
        end
        idleCycles(2);
        @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
